// File: rtl/tick_rate_ctrl.sv
// rtl/tick_rate_ctrl.sv - controlled tick source for the HEX0 display counter
module tick_rate_ctrl #(
  parameter int          CNT_W = 28,
  parameter int unsigned DIV0  = 0,
  parameter int unsigned DIV1  = 29_999_999,
  parameter int unsigned DIV2  = 49_999_999,
  parameter int unsigned DIV3  = 99_999_999,
  parameter int          TC_W  = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      speed,
  input  logic            run,
  input  logic            step,
  output logic            tick,
  output logic            running,
  output logic [TC_W-1:0] tick_count
);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_speed_q;
  logic              r_tick;
  logic              r_running;
  logic [TC_W-1:0]   r_tick_count;
  logic [CNT_W-1:0]  w_div;

  // Reload value for the currently selected speed (live input, not speed_q).
  always_comb begin
    w_div = CNT_W'(DIV0);
    case (speed)
      2'b00:   w_div = CNT_W'(DIV0);
      2'b01:   w_div = CNT_W'(DIV1);
      2'b10:   w_div = CNT_W'(DIV2);
      default: w_div = CNT_W'(DIV3);
    endcase
  end

  // Run/stop FSM with down-counter; every output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_STOPPED;
      r_cnt        <= '0;
      r_speed_q    <= 2'b00;
      r_tick       <= 1'b0;
      r_running    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      case (r_state)
        ST_STOPPED: begin
          if (run) begin
            // Entering RUNNING: step on this edge is deliberately dropped.
            r_state   <= ST_RUNNING;
            r_running <= 1'b1;
            r_cnt     <= w_div;
            r_speed_q <= speed;
            r_tick    <= 1'b0;
          end else if (step && !r_tick) begin
            // Gate on !r_tick so a held step can never stretch the pulse.
            r_tick       <= 1'b1;
            r_tick_count <= r_tick_count + TC_W'(1);
          end else begin
            r_tick <= 1'b0;
          end
        end
        default: begin
          if (!run) begin
            r_state   <= ST_STOPPED;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_cnt     <= '0;
          end else if (speed != r_speed_q) begin
            // Speed change restarts the period and suppresses any due tick.
            r_cnt     <= w_div;
            r_speed_q <= speed;
            r_tick    <= 1'b0;
          end else if (r_cnt == '0) begin
            r_tick       <= 1'b1;
            r_tick_count <= r_tick_count + TC_W'(1);
            r_cnt        <= w_div;
          end else begin
            r_tick <= 1'b0;
            r_cnt  <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign tick       = r_tick;
  assign running    = r_running;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// tb/tb_tick_rate_ctrl.sv - randomized self-checking bench for tick_rate_ctrl
module tb_tick_rate_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] speed;
  logic       run;
  logic       step;
  logic       tick;
  logic       running;
  logic [7:0] tick_count;

  int n_checks;
  int n_pass;

  // reference model state: elapsed edges within the current tick period
  bit m_active;
  int m_elapsed;
  int m_period;
  int m_speed_q;
  bit m_tick;
  int m_count;

  tick_rate_ctrl #(
    .CNT_W(28), .DIV0(0), .DIV1(2), .DIV2(4), .DIV3(9), .TC_W(8)
  ) dut (
    .clock(clock), .reset(reset), .speed(speed), .run(run), .step(step),
    .tick(tick), .running(running), .tick_count(tick_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int div_of(input int s);
    case (s)
      0: return 0;
      1: return 2;
      2: return 4;
      default: return 9;
    endcase
  endfunction

  // One clock edge of the behavioural model: a tick every DIV+1 running edges.
  task automatic model_edge(input bit a_rst, input bit a_run, input bit a_step, input int a_spd);
    if (a_rst) begin
      m_active = 0; m_elapsed = 0; m_period = 1; m_speed_q = 0; m_tick = 0; m_count = 0;
    end else if (!m_active) begin
      if (a_run) begin
        m_active = 1; m_elapsed = 0; m_period = div_of(a_spd) + 1; m_speed_q = a_spd; m_tick = 0;
      end else if (a_step && !m_tick) begin
        m_tick = 1; m_count = (m_count + 1) % 256;
      end else begin
        m_tick = 0;
      end
    end else begin
      if (!a_run) begin
        m_active = 0; m_tick = 0;
      end else if (a_spd != m_speed_q) begin
        m_elapsed = 0; m_period = div_of(a_spd) + 1; m_speed_q = a_spd; m_tick = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_period) begin
          m_tick = 1; m_count = (m_count + 1) % 256; m_elapsed = 0;
        end else begin
          m_tick = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit a_rst, input bit a_run, input bit a_step, input logic [1:0] a_spd);
    @(negedge clock);
    reset = a_rst; run = a_run; step = a_step; speed = a_spd;
    @(posedge clock);
    model_edge(a_rst, a_run, a_step, int'(a_spd));
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("running", 32'(running), 32'(m_active));
    check("tick_count", 32'(tick_count), 32'(m_count));
  endtask

  initial begin
    int last;
    int gap;
    int base;
    bit r_run;
    bit r_step;
    logic [1:0] r_spd;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; run = 1'b0; step = 1'b0; speed = 2'b00;
    model_edge(1, 0, 0, 0);

    // 1: reset, then speed 01 running until 10 ticks
    cyc(1, 0, 0, 2'b00);
    cyc(1, 0, 0, 2'b00);
    check("rst_tick", 32'(tick), 0);
    check("rst_running", 32'(running), 0);
    check("rst_count", 32'(tick_count), 0);
    cyc(0, 1, 0, 2'b01);
    check("enter_running", 32'(running), 1);
    for (int i = 0; i < 100 && m_count != 10; i++) cyc(0, 1, 0, 2'b01);
    check("count10", 32'(tick_count), 10);

    // 2: speed 00 ticks every cycle, then stop
    cyc(0, 0, 0, 2'b00);
    cyc(0, 1, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 2'b00);
      check("div0_tick", 32'(tick), 1);
    end
    cyc(0, 0, 0, 2'b00);
    check("stop_tick", 32'(tick), 0);
    check("stop_running", 32'(running), 0);

    // 3: three step pulses while stopped, then steps ignored at speed 11
    base = int'(tick_count);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 2'b11);
      check("step_tick", 32'(tick), 1);
      cyc(0, 0, 0, 2'b11);
      check("step_one_cycle", 32'(tick), 0);
    end
    check("step_count", 32'(tick_count), 32'((base + 3) % 256));
    cyc(0, 1, 0, 2'b11);
    last = -1;
    for (int i = 0; i < 45; i++) begin
      cyc(0, 1, $urandom_range(0, 1), 2'b11);
      if (tick) begin
        if (last >= 0) check("period11", 32'(i - last), 10);
        last = i;
      end
    end

    // 4: speed change exactly when the count is due restarts the period
    for (int i = 0; i < 20 && m_elapsed != m_period - 1; i++) cyc(0, 1, 0, 2'b11);
    check("due_reached", 32'(m_elapsed), 32'(m_period - 1));
    cyc(0, 1, 0, 2'b01);
    check("chg_no_tick", 32'(tick), 0);
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      for (int i = 0; i < 10; i++) begin
        cyc(0, 1, 0, 2'b01);
        gap++;
        if (tick) break;
      end
      check("chg_gap", 32'(gap), 3);
    end

    // 5: run and step together from STOPPED
    cyc(0, 0, 0, 2'b10);
    cyc(0, 0, 0, 2'b10);
    cyc(0, 1, 1, 2'b10);
    check("runstep_running", 32'(running), 1);
    check("runstep_tick", 32'(tick), 0);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 2'b10);
      gap++;
      if (tick) break;
    end
    check("runstep_first", 32'(gap), 5);

    // 6: reset mid-period, then wrap of tick_count
    cyc(0, 1, 0, 2'b11);
    cyc(0, 1, 0, 2'b11);
    cyc(1, 1, 0, 2'b11);
    check("midrst_tick", 32'(tick), 0);
    check("midrst_running", 32'(running), 0);
    check("midrst_count", 32'(tick_count), 0);
    cyc(0, 1, 0, 2'b00);
    for (int i = 0; i < 300 && m_count != 255; i++) cyc(0, 1, 0, 2'b00);
    check("count255", 32'(tick_count), 255);
    cyc(0, 1, 0, 2'b00);
    check("wrap", 32'(tick_count), 0);

    // random traffic
    r_run = 1'b0; r_step = 1'b0; r_spd = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) r_run = ~r_run;
      if ($urandom_range(0, 24) == 0) r_spd = 2'($urandom_range(0, 3));
      r_step = !r_step && ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 299) == 0, r_run, r_step, r_spd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
